// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo_buf: circular word buffer with occupancy count for the UART transmitter.
// Latency: a pushed word is visible at the head one edge after the push; no bypass path.
// Backpressure: full when DEPTH words are held; a push while full is ignored, a pop while empty is ignored.
module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data bits, parity and stop bits.
// Latency: word pushed at edge N into an idle, empty unit is popped at N+1; start bit is on tx after N+2.
// Backpressure: full reports a full FIFO; pushes while full are dropped and set the sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          full,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q;
  logic                 pop;
  logic                 baud_last;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head_dat;
  logic                 head_par;

  uart_tx_fifo_buf #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (start),
    .push_dat (data),
    .pop_vld  (pop),
    .pop_dat  (head_dat),
    .count    (fifo_count),
    .full     (full),
    .empty    (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  // Parity is fixed at pop time so the PAR state only replays a stored bit.
  assign head_par  = (PARITY == 2) ? ~^head_dat : ^head_dat;

  assign busy     = (state_q != S_IDLE) || !fifo_empty;
  assign overflow = ovf_q;
  assign tx       = tx_q;

  // Frame sequencer: next state, counters, shift register and the line level for this state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head_dat;
          par_d   = head_par;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PAR: begin
        tx_d = par_q;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next frame when a word is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head_dat;
              par_d   = head_par;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and the registered line driver; tx follows the state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Sticky overflow: any push attempt against a full FIFO, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (start && full) begin
      ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: three transmitter configurations driven from one stimulus stream.
// Every cycle each DUT is compared with a queue-and-frame reference model.
// Directed scenarios first, then randomized bursts with occasional resets.
module tb_uart_tx_fifo;

  localparam int C  = 4;
  localparam int NI = 3;
  localparam int D0 = 8, P0 = 0, S0 = 1, Q0 = 16;
  localparam int D1 = 8, P1 = 1, S1 = 2, Q1 = 4;
  localparam int D2 = 7, P2 = 2, S2 = 1, Q2 = 8;
  localparam int CD [NI] = '{D0, D1, D2};
  localparam int CP [NI] = '{P0, P1, P2};
  localparam int CS [NI] = '{S0, S1, S2};
  localparam int CQ [NI] = '{Q0, Q1, Q2};

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] data;
  logic       full_w [NI];
  logic       busy_w [NI];
  logic       ovf_w  [NI];
  logic       tx_w   [NI];
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  logic [3:0] cnt2;

  always #50 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(D0), .PARITY(P0), .STOP_BITS(S0), .FIFO_DEPTH(Q0)) u0 (
    .clk(clk), .rst(rst), .start(start), .data(data[D0-1:0]), .full(full_w[0]),
    .busy(busy_w[0]), .fifo_count(cnt0), .overflow(ovf_w[0]), .tx(tx_w[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(D1), .PARITY(P1), .STOP_BITS(S1), .FIFO_DEPTH(Q1)) u1 (
    .clk(clk), .rst(rst), .start(start), .data(data[D1-1:0]), .full(full_w[1]),
    .busy(busy_w[1]), .fifo_count(cnt1), .overflow(ovf_w[1]), .tx(tx_w[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(D2), .PARITY(P2), .STOP_BITS(S2), .FIFO_DEPTH(Q2)) u2 (
    .clk(clk), .rst(rst), .start(start), .data(data[D2-1:0]), .full(full_w[2]),
    .busy(busy_w[2]), .fifo_count(cnt2), .overflow(ovf_w[2]), .tx(tx_w[2]));

  // Reference model state per instance: FIFO contents, frame in flight, line level.
  logic [8:0] mbuf  [NI][16];
  int         mhead [NI];
  int         mcnt  [NI];
  int         mleft [NI];
  bit         mact  [NI];
  logic [8:0] mword [NI];
  bit         mtx   [NI];
  bit         movf  [NI];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int frame_len(input int i);
    return (1 + CD[i] + ((CP[i] != 0) ? 1 : 0) + CS[i]) * C;
  endfunction

  function automatic logic [8:0] word_mask(input int i);
    logic [8:0] m;
    m = '0;
    for (int k = 0; k < CD[i]; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Line level during cycle idx of a frame: start, LSB-first data, optional parity, stop.
  function automatic bit frame_level(input int i, input int idx);
    int b;
    bit p;
    logic [8:0] w;
    b = idx / C;
    w = mword[i];
    p = ^w;
    if (CP[i] == 2) p = ~p;
    if (b == 0) return 1'b0;
    if (b <= CD[i]) return w[b-1];
    if (CP[i] != 0 && b == CD[i] + 1) return p;
    return 1'b1;
  endfunction

  task automatic model_step(input int i);
    int  pre;
    int  tail;
    bit  txn;
    if (rst) begin
      mcnt[i] = 0; mhead[i] = 0; mact[i] = 0; mleft[i] = 0; mtx[i] = 1; movf[i] = 0;
      return;
    end
    txn  = mact[i] ? frame_level(i, frame_len(i) - mleft[i]) : 1'b1;
    pre  = mcnt[i];
    tail = (mhead[i] + pre) % CQ[i];
    if (mact[i]) begin
      mleft[i]--;
      if (mleft[i] == 0) mact[i] = 0;
    end
    if (!mact[i] && pre > 0) begin
      mword[i] = mbuf[i][mhead[i]];
      mhead[i] = (mhead[i] + 1) % CQ[i];
      mcnt[i]--;
      mact[i]  = 1;
      mleft[i] = frame_len(i);
    end
    if (start) begin
      if (pre == CQ[i]) begin
        movf[i] = 1;
      end else begin
        mbuf[i][tail] = data & word_mask(i);
        mcnt[i]++;
      end
    end
    mtx[i] = txn;
  endtask

  function automatic int dut_cnt(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d tx", i),         int'(tx_w[i]),   int'(mtx[i]));
      chk($sformatf("u%0d busy", i),       int'(busy_w[i]), (mact[i] || mcnt[i] > 0) ? 1 : 0);
      chk($sformatf("u%0d fifo_count", i), dut_cnt(i),      mcnt[i]);
      chk($sformatf("u%0d full", i),       int'(full_w[i]), (mcnt[i] == CQ[i]) ? 1 : 0);
      chk($sformatf("u%0d overflow", i),   int'(ovf_w[i]),  int'(movf[i]));
    end
  endtask

  // One clock: model advances on the rising edge, outputs are compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [8:0] d);
    start = 1'b1;
    data  = d;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int rate;
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    for (int i = 0; i < NI; i++) begin
      mhead[i] = 0; mcnt[i] = 0; mleft[i] = 0; mact[i] = 0; mword[i] = '0; mtx[i] = 1; movf[i] = 0;
    end
    idle(2);
    rst = 1'b0;
    chk("reset tx", int'(tx_w[0]), 1);
    chk("reset busy", int'(busy_w[0]), 0);
    chk("reset count", int'(cnt0), 0);

    // 8N1 single word, then parity / two-stop word.
    push(9'h055);
    idle(50);
    push(9'h007);
    idle(60);

    // Burst into a busy transmitter: the depth-4 instance fills and drops the last word.
    push(9'h099);
    push(9'h011);
    push(9'h022);
    push(9'h033);
    push(9'h044);
    push(9'h055);
    chk("burst full u1", int'(full_w[1]), 1);
    chk("burst overflow u1", int'(ovf_w[1]), 1);
    chk("burst overflow u0", int'(ovf_w[0]), 0);
    idle(300);

    // Back-to-back frames with no idle gap.
    push(9'h0A0);
    push(9'h00F);
    idle(120);

    // Reset in the middle of a data phase with two words queued.
    push(9'h0C3);
    push(9'h001);
    push(9'h002);
    idle(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midframe rst tx", int'(tx_w[0]), 1);
    chk("midframe rst busy", int'(busy_w[0]), 0);
    chk("midframe rst count", int'(cnt0), 0);
    chk("midframe rst overflow u1", int'(ovf_w[1]), 0);
    push(9'h03C);
    idle(60);

    // Push on the same edge the 8N1 unit pops with two words held.
    push(9'h0B1);
    push(9'h0B2);
    push(9'h0B3);
    idle(frame_len(0) - 2);
    push(9'h05A);
    chk("push+pop count", int'(cnt0), 2);
    idle(200);

    // Randomized traffic with varying push density and rare resets.
    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 2))
        0:       rate = 2;
        1:       rate = 10;
        default: rate = 60;
      endcase
      for (int c = 0; c < 200; c++) begin
        rst   = ($urandom_range(0, 999) == 0);
        start = ($urandom_range(0, 99) < rate);
        data  = 9'($urandom);
        tick();
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    idle(16 * 48 + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
